// File: rtl/tile_trace_monitor_if.sv
// ============================================================================
// Module  : tile_trace_monitor_if
// Purpose : Writeback-stage tap bundle between the core and its trace monitor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface tile_trace_monitor_if;
  logic        enable;
  logic [31:0] wb_pc;
  logic [31:0] wb_insn;
  logic [31:0] r3;
  logic        supv;

  modport master (output enable, wb_pc, wb_insn, r3, supv);
  modport slave  (input  enable, wb_pc, wb_insn, r3, supv);
endinterface

`default_nettype wire

// File: rtl/tile_trace_monitor.sv
// ============================================================================
// Module  : tile_trace_monitor
// Purpose : Registers every retired instruction and decodes l.nop K exit/report/putc.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tile_trace_monitor #(
  // File names for the simulator-side loggers; the datapath does not use them.
  parameter string stdout_filename    = "stdout",
  parameter string tracefile_filename = "trace"
) (
  input  wire logic               clk,
  input  wire logic               rst,
  tile_trace_monitor_if.slave     wb,
  input  wire logic               if_valid_en,
  input  wire logic [31:0]        if_valid_pos,
  input  wire logic               ctrl_done_en,
  input  wire logic [31:0]        ctrl_done_pos,
  output logic                    trace_valid,
  output logic [31:0]             trace_pc,
  output logic [31:0]             trace_insn,
  output logic                    trace_supv,
  output logic                    char_valid,
  output logic [7:0]              char_data,
  output logic                    report_valid,
  output logic [31:0]             report_data,
  output logic                    exit_valid,
  output logic [31:0]             exit_code,
  output logic                    terminated,
  output logic                    if_valid_hit,
  output logic                    ctrl_done,
  output logic [31:0]             insn_count
);

  localparam logic [15:0] C_NOP_OPCODE = 16'h1500;
  localparam logic [15:0] C_NOP_EXIT   = 16'h0001;
  localparam logic [15:0] C_NOP_REPORT = 16'h0002;
  localparam logic [15:0] C_NOP_PUTC   = 16'h0004;

  logic        trace_valid_q,  trace_valid_d;
  logic [31:0] trace_pc_q,     trace_pc_d;
  logic [31:0] trace_insn_q,   trace_insn_d;
  logic        trace_supv_q,   trace_supv_d;
  logic        char_valid_q,   char_valid_d;
  logic [7:0]  char_data_q,    char_data_d;
  logic        report_valid_q, report_valid_d;
  logic [31:0] report_data_q,  report_data_d;
  logic        exit_valid_q,   exit_valid_d;
  logic [31:0] exit_code_q,    exit_code_d;
  logic        terminated_q,   terminated_d;
  logic        if_valid_hit_q, if_valid_hit_d;
  logic        ctrl_done_q,    ctrl_done_d;
  logic [31:0] insn_count_q,   insn_count_d;

  logic w_accept;
  logic w_is_nop;
  logic w_exit;
  logic w_report;
  logic w_putc;

  // Once exit has retired the monitor goes deaf until reset.
  assign w_accept = wb.enable && !terminated_q;
  assign w_is_nop = (wb.wb_insn[31:16] == C_NOP_OPCODE);
  assign w_exit   = w_accept && w_is_nop && (wb.wb_insn[15:0] == C_NOP_EXIT);
  assign w_report = w_accept && w_is_nop && (wb.wb_insn[15:0] == C_NOP_REPORT);
  assign w_putc   = w_accept && w_is_nop && (wb.wb_insn[15:0] == C_NOP_PUTC);

  always_comb begin
    trace_valid_d  = w_accept;
    trace_pc_d     = trace_pc_q;
    trace_insn_d   = trace_insn_q;
    trace_supv_d   = trace_supv_q;
    insn_count_d   = insn_count_q;
    char_valid_d   = w_putc;
    char_data_d    = char_data_q;
    report_valid_d = w_report;
    report_data_d  = report_data_q;
    exit_valid_d   = w_exit;
    exit_code_d    = exit_code_q;
    terminated_d   = terminated_q | w_exit;
    if_valid_hit_d = w_accept && if_valid_en && (wb.wb_pc == if_valid_pos);
    ctrl_done_d    = ctrl_done_q |
                     (w_accept && ctrl_done_en && (wb.wb_pc == ctrl_done_pos));

    if (w_accept) begin
      trace_pc_d   = wb.wb_pc;
      trace_insn_d = wb.wb_insn;
      trace_supv_d = wb.supv;
      insn_count_d = insn_count_q + 32'd1;
    end
    if (w_putc)   char_data_d   = wb.r3[7:0];
    if (w_report) report_data_d = wb.r3;
    if (w_exit)   exit_code_d   = wb.r3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trace_valid_q  <= 1'b0;
      trace_pc_q     <= 32'd0;
      trace_insn_q   <= 32'd0;
      trace_supv_q   <= 1'b0;
      char_valid_q   <= 1'b0;
      char_data_q    <= 8'd0;
      report_valid_q <= 1'b0;
      report_data_q  <= 32'd0;
      exit_valid_q   <= 1'b0;
      exit_code_q    <= 32'd0;
      terminated_q   <= 1'b0;
      if_valid_hit_q <= 1'b0;
      ctrl_done_q    <= 1'b0;
      insn_count_q   <= 32'd0;
    end else begin
      trace_valid_q  <= trace_valid_d;
      trace_pc_q     <= trace_pc_d;
      trace_insn_q   <= trace_insn_d;
      trace_supv_q   <= trace_supv_d;
      char_valid_q   <= char_valid_d;
      char_data_q    <= char_data_d;
      report_valid_q <= report_valid_d;
      report_data_q  <= report_data_d;
      exit_valid_q   <= exit_valid_d;
      exit_code_q    <= exit_code_d;
      terminated_q   <= terminated_d;
      if_valid_hit_q <= if_valid_hit_d;
      ctrl_done_q    <= ctrl_done_d;
      insn_count_q   <= insn_count_d;
    end
  end

  assign trace_valid  = trace_valid_q;
  assign trace_pc     = trace_pc_q;
  assign trace_insn   = trace_insn_q;
  assign trace_supv   = trace_supv_q;
  assign char_valid   = char_valid_q;
  assign char_data    = char_data_q;
  assign report_valid = report_valid_q;
  assign report_data  = report_data_q;
  assign exit_valid   = exit_valid_q;
  assign exit_code    = exit_code_q;
  assign terminated   = terminated_q;
  assign if_valid_hit = if_valid_hit_q;
  assign ctrl_done    = ctrl_done_q;
  assign insn_count   = insn_count_q;

endmodule

`default_nettype wire

// File: tb/tb_tile_trace_monitor.sv
// ============================================================================
// Module  : tb_tile_trace_monitor
// Purpose : Directed bench for tile_trace_monitor with hand-computed expectations.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tile_trace_monitor;

  logic        clk;
  logic        rst;
  logic        if_valid_en;
  logic [31:0] if_valid_pos;
  logic        ctrl_done_en;
  logic [31:0] ctrl_done_pos;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_insn;
  logic        trace_supv;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        report_valid;
  logic [31:0] report_data;
  logic        exit_valid;
  logic [31:0] exit_code;
  logic        terminated;
  logic        if_valid_hit;
  logic        ctrl_done;
  logic [31:0] insn_count;

  int n_checks;
  int n_errors;

  tile_trace_monitor_if bus ();

  tile_trace_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .wb            (bus.slave),
    .if_valid_en   (if_valid_en),
    .if_valid_pos  (if_valid_pos),
    .ctrl_done_en  (ctrl_done_en),
    .ctrl_done_pos (ctrl_done_pos),
    .trace_valid   (trace_valid),
    .trace_pc      (trace_pc),
    .trace_insn    (trace_insn),
    .trace_supv    (trace_supv),
    .char_valid    (char_valid),
    .char_data     (char_data),
    .report_valid  (report_valid),
    .report_data   (report_data),
    .exit_valid    (exit_valid),
    .exit_code     (exit_code),
    .terminated    (terminated),
    .if_valid_hit  (if_valid_hit),
    .ctrl_done     (ctrl_done),
    .insn_count    (insn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pulse outputs packed as {trace, char, report, exit, if_hit}.
  function automatic logic [31:0] pulses();
    return {27'd0, trace_valid, char_valid, report_valid, exit_valid, if_valid_hit};
  endfunction

  // Presents one retirement for exactly one cycle and samples just after the edge.
  task automatic retire(input logic [31:0] pc, input logic [31:0] insn,
                        input logic [31:0] r3v, input logic sv);
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.wb_pc   = pc;
    bus.wb_insn = insn;
    bus.r3      = r3v;
    bus.supv    = sv;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.enable = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.enable    = 1'b0;
    bus.wb_pc     = 32'd0;
    bus.wb_insn   = 32'd0;
    bus.r3        = 32'd0;
    bus.supv      = 1'b0;
    if_valid_en   = 1'b0;
    if_valid_pos  = 32'd0;
    ctrl_done_en  = 1'b0;
    ctrl_done_pos = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    check("rst_pulses",     pulses(),    32'd0);
    check("rst_count",      insn_count,  32'd0);
    check("rst_term",       {31'd0, terminated}, 32'd0);
    check("rst_done",       {31'd0, ctrl_done},  32'd0);
    check("rst_exit_code",  exit_code,   32'd0);
    check("rst_trace_pc",   trace_pc,    32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("idle_pulses", pulses(), 32'd0);
    end
    check("idle_count", insn_count, 32'd0);

    retire(32'h100, 32'hE000_0000, 32'd0, 1'b0);
    check("seq0_valid", {31'd0, trace_valid}, 32'd1);
    check("seq0_pc",    trace_pc,   32'h100);
    check("seq0_insn",  trace_insn, 32'hE000_0000);
    retire(32'h104, 32'hE000_0000, 32'd0, 1'b1);
    check("seq1_valid", {31'd0, trace_valid}, 32'd1);
    check("seq1_pc",    trace_pc,   32'h104);
    check("seq1_supv",  {31'd0, trace_supv}, 32'd1);
    retire(32'h108, 32'hE000_0000, 32'd0, 1'b0);
    check("seq2_pc",    trace_pc,   32'h108);
    check("seq2_count", insn_count, 32'd3);
    idle(1);
    check("seq_gap_pulses", pulses(), 32'd0);
    check("seq_gap_hold",   trace_pc, 32'h108);

    retire(32'h10C, 32'h1500_0004, 32'h0000_0041, 1'b0);
    check("putc_pulses", pulses(), 32'b11000);
    check("putc_data",   {24'd0, char_data}, 32'h41);
    retire(32'h110, 32'h1500_0002, 32'hDEAD_BEEF, 1'b0);
    check("report_pulses", pulses(), 32'b10100);
    check("report_data",   report_data, 32'hDEAD_BEEF);
    check("putc_hold",     {24'd0, char_data}, 32'h41);
    retire(32'h114, 32'h1500_0000, 32'h1234_5678, 1'b0);
    check("nop0_pulses", pulses(), 32'b10000);
    check("nop0_count",  insn_count, 32'd6);
    check("nop0_report_hold", report_data, 32'hDEAD_BEEF);

    if_valid_en   = 1'b1;
    if_valid_pos  = 32'h1FC;
    ctrl_done_en  = 1'b1;
    ctrl_done_pos = 32'h200;
    retire(32'h1FC, 32'hE000_0000, 32'd0, 1'b0);
    check("ifhit_pulses", pulses(), 32'b10001);
    check("ifhit_done",   {31'd0, ctrl_done}, 32'd0);
    retire(32'h200, 32'hE000_0000, 32'd0, 1'b0);
    check("done_pulses", pulses(), 32'b10000);
    check("done_set",    {31'd0, ctrl_done}, 32'd1);
    idle(3);
    check("done_sticky", {31'd0, ctrl_done}, 32'd1);
    check("done_count",  insn_count, 32'd8);

    retire(32'h204, 32'h1500_0001, 32'd7, 1'b0);
    check("exit_pulses", pulses(), 32'b10010);
    check("exit_code",   exit_code, 32'd7);
    check("exit_term",   {31'd0, terminated}, 32'd1);
    check("exit_count",  insn_count, 32'd9);
    retire(32'h208, 32'h1500_0004, 32'h55, 1'b0);
    check("post_exit_pulses", pulses(), 32'd0);
    check("post_exit_count",  insn_count, 32'd9);
    check("post_exit_char",   {24'd0, char_data}, 32'h41);
    check("post_exit_pc",     trace_pc, 32'h204);
    retire(32'h1FC, 32'h1500_0001, 32'd9, 1'b0);
    check("post_exit_ifhit",  pulses(), 32'd0);
    check("post_exit_code",   exit_code, 32'd7);

    // Reset with a retirement presented in the same cycle: it must be dropped.
    @(negedge clk);
    rst         = 1'b1;
    bus.enable  = 1'b1;
    bus.wb_pc   = 32'h1FC;
    bus.wb_insn = 32'h1500_0004;
    bus.r3      = 32'h66;
    @(posedge clk);
    #1;
    check("rst_mid_pulses", pulses(), 32'd0);
    check("rst_mid_count",  insn_count, 32'd0);
    check("rst_mid_term",   {31'd0, terminated}, 32'd0);
    check("rst_mid_done",   {31'd0, ctrl_done}, 32'd0);
    check("rst_mid_code",   exit_code, 32'd0);
    check("rst_mid_char",   {24'd0, char_data}, 32'd0);
    bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    if_valid_en = 1'b0;
    retire(32'h1FC, 32'hE000_0000, 32'd0, 1'b0);
    check("ifhit_disabled", pulses(), 32'b10000);

    ctrl_done_pos = 32'h300;
    if_valid_pos  = 32'h300;
    if_valid_en   = 1'b1;
    retire(32'h300, 32'h1500_0001, 32'h0000_00FF, 1'b0);
    check("simul_pulses", pulses(), 32'b10011);
    check("simul_done",   {31'd0, ctrl_done},  32'd1);
    check("simul_term",   {31'd0, terminated}, 32'd1);
    check("simul_code",   exit_code, 32'hFF);
    check("simul_count",  insn_count, 32'd2);

    do_reset();
    if_valid_en  = 1'b0;
    ctrl_done_en = 1'b0;
    @(negedge clk);
    force dut.insn_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.insn_count_q;
    retire(32'h400, 32'hE000_0000, 32'd0, 1'b0);
    check("wrap_ffff", insn_count, 32'hFFFF_FFFF);
    retire(32'h404, 32'hE000_0000, 32'd0, 1'b0);
    check("wrap_zero", insn_count, 32'd0);
    retire(32'h408, 32'hE000_0000, 32'd0, 1'b0);
    check("wrap_one",  insn_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
